// File: rtl/updown_counter_monitor.sv
// ---------------------------------------------------------------------------
// updown_counter_monitor
//
// Purpose:
//   Checker stage that sits directly downstream of the up/down counter. It
//   snoops the counter's instruction and value on the shared clock and reset.
//   From these it:
//     - predicts the next counter value and flags step mismatches,
//     - keeps a sticky fault flag and a saturating mismatch count,
//     - pulses on wrap-around in either direction,
//     - raises a hysteresis threshold alarm.
//   The block only observes; it never drives the counter. All outputs are
//   registered.
//
// Ports:
//   clock      in   1         rising-edge clock, shared with the counter
//   reset      in   1         synchronous, active-high (same net as counter)
//   inst       in   1         counter instruction: 0 = count up, 1 = count down
//   value      in   WIDTH     counter output value
//   mismatch   out  1         one-cycle pulse: sampled value != predicted value
//   fault      out  1         sticky; set by first mismatch, cleared by reset
//   err_count  out  ERRCNT_W  mismatch count, saturates at all-ones
//   wrap_up    out  1         one-cycle pulse: counter wraps max -> 0
//   wrap_down  out  1         one-cycle pulse: counter wraps 0 -> max
//   alarm      out  1         hysteresis threshold alarm level
// ---------------------------------------------------------------------------
module updown_counter_monitor #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned HI_THRESH = 1000,
    parameter int unsigned LO_THRESH = 900,
    parameter int unsigned ERRCNT_W  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inst,
    input  logic [WIDTH-1:0]    value,
    output logic                mismatch,
    output logic                fault,
    output logic [ERRCNT_W-1:0] err_count,
    output logic                wrap_up,
    output logic                wrap_down,
    output logic                alarm
);

    localparam logic [WIDTH-1:0]    HI_V    = WIDTH'(HI_THRESH);
    localparam logic [WIDTH-1:0]    LO_V    = WIDTH'(LO_THRESH);
    localparam logic [WIDTH-1:0]    ONE_V   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]    ZERO_V  = '0;
    localparam logic [WIDTH-1:0]    MAX_V   = '1;
    localparam logic [ERRCNT_W-1:0] ERR_ONE = {{(ERRCNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERRCNT_W-1:0] ERR_MAX = '1;

    typedef enum logic {RUN,  FAULT} chk_state_t;
    typedef enum logic {NORM, ALRM}  alm_state_t;

    chk_state_t          chk_state_q, chk_state_d;
    alm_state_t          alm_state_q, alm_state_d;
    logic [WIDTH-1:0]    exp_q,       exp_d;
    logic                chk_en_q,    chk_en_d;
    logic                mismatch_q,  mismatch_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;
    logic                wrap_up_q,   wrap_up_d;
    logic                wrap_down_q, wrap_down_d;
    logic                mis;

    always_ff @(posedge clock) begin
        chk_state_q <= chk_state_d;
        alm_state_q <= alm_state_d;
        exp_q       <= exp_d;
        chk_en_q    <= chk_en_d;
        mismatch_q  <= mismatch_d;
        err_count_q <= err_count_d;
        wrap_up_q   <= wrap_up_d;
        wrap_down_q <= wrap_down_d;
    end

    always_comb begin
        chk_state_d = chk_state_q;
        alm_state_d = alm_state_q;
        exp_d       = exp_q;
        chk_en_d    = chk_en_q;
        mismatch_d  = 1'b0;
        err_count_d = err_count_q;
        wrap_up_d   = 1'b0;
        wrap_down_d = 1'b0;
        mis         = chk_en_q && (value != exp_q);

        if (reset) begin
            // Reset wins over everything, including a pending mismatch.
            chk_state_d = RUN;
            alm_state_d = NORM;
            exp_d       = ZERO_V;
            chk_en_d    = 1'b1;
            err_count_d = '0;
        end else begin
            mismatch_d = mis;
            if (mis) begin
                // FAULT is absorbing; only reset leaves it.
                chk_state_d = FAULT;
                if (err_count_q != ERR_MAX) begin
                    err_count_d = err_count_q + ERR_ONE;
                end
            end

            // Predict from the observed value so a single corrupted sample
            // produces exactly one mismatch rather than a persistent one.
            exp_d = inst ? (value - ONE_V) : (value + ONE_V);

            wrap_up_d   = !inst && (value == MAX_V);
            wrap_down_d =  inst && (value == ZERO_V);

            case (alm_state_q)
                NORM:    if (value >= HI_V) alm_state_d = ALRM;
                ALRM:    if (value <= LO_V) alm_state_d = NORM;
                default: alm_state_d = NORM;
            endcase
        end
    end

    assign mismatch  = mismatch_q;
    assign fault     = (chk_state_q == FAULT);
    assign err_count = err_count_q;
    assign wrap_up   = wrap_up_q;
    assign wrap_down = wrap_down_q;
    assign alarm     = (alm_state_q == ALRM);

endmodule

// File: tb/tb_updown_counter_monitor.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_monitor
//
// Drives the monitor with a bench-side counter whose next value follows the
// value it displayed (so a forced glitch is a one-off). A behavioural model
// predicts every output each cycle; directed literal checks pin key points.
// ---------------------------------------------------------------------------
module tb_updown_counter_monitor;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        inst  = 1'b0;
    logic [31:0] value = '0;
    logic        mismatch, fault, wrap_up, wrap_down, alarm;
    logic [7:0]  err_count;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] cnt = '0;

    updown_counter_monitor #(
        .WIDTH(32), .HI_THRESH(1000), .LO_THRESH(900), .ERRCNT_W(8)
    ) dut (
        .clock(clock), .reset(reset), .inst(inst), .value(value),
        .mismatch(mismatch), .fault(fault), .err_count(err_count),
        .wrap_up(wrap_up), .wrap_down(wrap_down), .alarm(alarm)
    );

    always #5 clock = ~clock;

    // Behavioural model, stepped at every rising edge from the sampled inputs.
    bit          m_valid = 0;
    logic [31:0] m_exp   = '0;
    bit          m_mis = 0, m_fault = 0, m_wu = 0, m_wd = 0, m_alarm = 0;
    int          m_err = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_valid = 1; m_exp = 0; m_mis = 0; m_fault = 0;
            m_err = 0; m_wu = 0; m_wd = 0; m_alarm = 0;
        end else if (m_valid) begin
            m_mis = (value != m_exp);
            if (m_mis) begin
                m_fault = 1;
                if (m_err < 255) m_err = m_err + 1;
            end
            m_exp = inst ? value - 32'd1 : value + 32'd1;
            m_wu  = (inst == 0) && (value == 32'hFFFF_FFFF);
            m_wd  = (inst == 1) && (value == 32'd0);
            if (value >= 32'd1000)     m_alarm = 1;
            else if (value <= 32'd900) m_alarm = 0;
        end
    end

    // Compare process: outputs against the model on every falling edge.
    always @(negedge clock) begin
        if (m_valid) begin
            logic [12:0] act, req;
            act = {mismatch, fault, err_count, wrap_up, wrap_down, alarm};
            req = {m_mis, m_fault, 8'(m_err), m_wu, m_wd, m_alarm};
            n_total++;
            if (act === req) n_pass++;
            else $display("FAIL model_cmp t=%0t value=%0d actual=%b required=%b",
                          $time, value, act, req);
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // One clock: drive at negedge, let the DUT sample, advance the counter.
    task automatic cyc(input bit r, input bit i);
        @(negedge clock);
        reset = r; inst = i; value = cnt;
        @(posedge clock);
        cnt = r ? 32'd0 : (i ? cnt - 32'd1 : cnt + 32'd1);
        #1;
    endtask

    initial begin
        // 1: reset, then count up 0..9 (counter shows 10 next)
        cyc(1, 0); cyc(1, 0);
        lit("reset_outputs", {26'd0, mismatch, fault, wrap_up, wrap_down, alarm, |err_count}, 32'd0);
        repeat (10) cyc(0, 0);
        lit("t1_cnt", cnt, 32'd10);
        lit("t1_fault", {31'd0, fault}, 32'd0);
        lit("t1_errcnt", {24'd0, err_count}, 32'd0);
        lit("t1_alarm", {31'd0, alarm}, 32'd0);

        // 2: single glitch 5 instead of 4
        cyc(1, 0);
        repeat (4) cyc(0, 0);
        cnt = 32'd5;
        cyc(0, 0);
        lit("t2_mismatch", {31'd0, mismatch}, 32'd1);
        lit("t2_fault", {31'd0, fault}, 32'd1);
        lit("t2_errcnt", {24'd0, err_count}, 32'd1);
        repeat (3) cyc(0, 0);
        lit("t2_no_more_mis", {31'd0, mismatch}, 32'd0);
        lit("t2_fault_sticky", {31'd0, fault}, 32'd1);
        lit("t2_errcnt_hold", {24'd0, err_count}, 32'd1);

        // 3: wrap down then wrap up
        cyc(1, 0); cyc(1, 0);
        cyc(0, 1);
        lit("t3_wrap_down", {31'd0, wrap_down}, 32'd1);
        lit("t3_value_max", cnt, 32'hFFFF_FFFF);
        cyc(0, 0);
        lit("t3_wrap_down_end", {31'd0, wrap_down}, 32'd0);
        lit("t3_wrap_up", {31'd0, wrap_up}, 32'd1);
        lit("t3_value_zero", cnt, 32'd0);
        lit("t3_no_mis", {31'd0, mismatch}, 32'd0);
        cyc(0, 0);
        lit("t3_wrap_up_end", {31'd0, wrap_up}, 32'd0);

        // 4: alarm hysteresis
        cyc(1, 0);
        repeat (1000) cyc(0, 0);
        lit("t4_alarm_999", {31'd0, alarm}, 32'd0);
        cyc(0, 0);
        lit("t4_alarm_1000", {31'd0, alarm}, 32'd1);
        while (cnt != 32'd901) cyc(0, 1);
        cyc(0, 1);
        lit("t4_alarm_901", {31'd0, alarm}, 32'd1);
        cyc(0, 1);
        lit("t4_alarm_900", {31'd0, alarm}, 32'd0);
        lit("t4_fault", {31'd0, fault}, 32'd0);

        // 5: 300 mismatches saturate, then mid-run reset
        repeat (300) begin
            cnt = cnt + 32'd5;
            cyc(0, 0);
        end
        lit("t5_saturate", {24'd0, err_count}, 32'hFF);
        lit("t5_fault", {31'd0, fault}, 32'd1);
        cnt = cnt + 32'd5;
        cyc(1, 0);
        lit("t5_reset_all", {26'd0, mismatch, fault, wrap_up, wrap_down, alarm, |err_count}, 32'd0);

        // 6: reset with a bad value, then 0 accepted
        repeat (3) cyc(0, 0);
        cnt = 32'd77;
        cyc(1, 0);
        lit("t6_no_mis_reset", {31'd0, mismatch}, 32'd0);
        cyc(0, 0);
        lit("t6_zero_ok", {31'd0, mismatch}, 32'd0);
        lit("t6_fault", {31'd0, fault}, 32'd0);

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
